// File: rtl/prbs7_checker.sv
// PRBS7 (x^7+x^6+1) serial checker: self-seeding search, lock detection,
// windowed loss-of-lock and a saturating bit-error counter.
module prbs7_checker #(
    parameter int LOCK_CNT   = 16,
    parameter int UNLOCK_ERR = 4,
    parameter int CNT_W      = 16
) (
    input  logic             CK,
    input  logic             RN,
    input  logic             din_valid,
    input  logic             din,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [0:0] SEARCH = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    localparam logic [7:0]       LOCK_TGT   = 8'(LOCK_CNT);
    localparam logic [6:0]       UNLOCK_TGT = 7'(UNLOCK_ERR);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [0:0] state;
    logic [6:0] sr;
    logic [2:0] fill_cnt;
    logic [7:0] match_cnt;
    logic [6:0] win_cnt;
    logic [6:0] err_win;

    logic       predicted;
    logic       is_match;
    logic       bit_err;
    logic       win_wrap;
    logic [6:0] err_win_nxt;
    logic [7:0] match_nxt;
    logic       unlock;

    always_comb begin
        predicted   = sr[6] ^ sr[5];
        // The all-zero register is a lock-up state of the LFSR, never a valid match.
        is_match    = (din == predicted) && (sr != 7'd0);
        bit_err     = din_valid && (state == LOCKED) && (din != predicted);
        win_wrap    = (win_cnt == 7'd127);
        err_win_nxt = win_wrap ? 7'd1 : err_win + 7'd1;
        match_nxt   = match_cnt + 8'd1;
        unlock      = bit_err && (err_win_nxt == UNLOCK_TGT);
    end

    assign locked = state[0];

    // NOTE: every register below uses <= so all flops sample pre-edge values;
    // blocking assignments here would create order-dependent simulation races.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state     <= SEARCH;
            sr        <= 7'd0;
            fill_cnt  <= 3'd0;
            match_cnt <= 8'd0;
            win_cnt   <= 7'd0;
            err_win   <= 7'd0;
        end else if (din_valid) begin
            case (state)
                SEARCH: begin
                    sr <= {sr[5:0], din};
                    if (fill_cnt != 3'd7) begin
                        fill_cnt <= fill_cnt + 3'd1;
                    end else if (!is_match) begin
                        match_cnt <= 8'd0;
                    end else if (match_nxt == LOCK_TGT) begin
                        state     <= LOCKED;
                        match_cnt <= 8'd0;
                        win_cnt   <= 7'd0;
                        err_win   <= 7'd0;
                    end else begin
                        match_cnt <= match_nxt;
                    end
                end
                default: begin
                    // Free-running reference: incoming errors never corrupt the predictor.
                    sr      <= {sr[5:0], predicted};
                    win_cnt <= win_cnt + 7'd1;
                    if (win_wrap) begin
                        err_win <= {6'd0, bit_err};
                    end else if (bit_err) begin
                        err_win <= err_win_nxt;
                    end
                    if (unlock) begin
                        state     <= SEARCH;
                        fill_cnt  <= 3'd0;
                        match_cnt <= 8'd0;
                        win_cnt   <= 7'd0;
                        err_win   <= 7'd0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            err_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            err_pulse <= bit_err;
            // Clear wins over increment, but an error in the clear cycle still counts.
            if (clear) begin
                err_count <= bit_err ? CNT_ONE : '0;
            end else if (bit_err && (err_count != CNT_MAX)) begin
                err_count <= err_count + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_prbs7_checker.sv
// Directed self-checking bench for prbs7_checker; a second instance with a
// 4-bit counter and a high unlock threshold exercises counter saturation.
module tb_prbs7_checker;

    logic        CK = 1'b0;
    logic        RN = 1'b0;
    logic        din_valid = 1'b0;
    logic        din = 1'b0;
    logic        clear = 1'b0;
    logic        locked, err_pulse;
    logic [15:0] err_count;
    logic        locked4, err_pulse4;
    logic [3:0]  err_count4;

    int          checks = 0;
    int          errors = 0;
    int          pulse_cnt = 0;
    int          locked_seen = 0;
    logic [6:0]  g = 7'h7F;

    prbs7_checker dut (
        .CK(CK), .RN(RN), .din_valid(din_valid), .din(din), .clear(clear),
        .locked(locked), .err_pulse(err_pulse), .err_count(err_count)
    );

    prbs7_checker #(.LOCK_CNT(16), .UNLOCK_ERR(127), .CNT_W(4)) dut4 (
        .CK(CK), .RN(RN), .din_valid(din_valid), .din(din), .clear(clear),
        .locked(locked4), .err_pulse(err_pulse4), .err_count(err_count4)
    );

    always #5 CK = ~CK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input logic v, input logic b, input logic c);
        din_valid = v;
        din       = b;
        clear     = c;
        @(posedge CK);
        #1;
        if (locked) locked_seen++;
        if (err_pulse) pulse_cnt++;
    endtask

    // Sends n bits of the reference PRBS7 stream, optionally inverted.
    task automatic prbs_bits(input int n, input logic inv, input logic c);
        logic b;
        for (int i = 0; i < n; i++) begin
            b = g[6] ^ g[5];
            g = {g[5:0], b};
            step(1'b1, b ^ inv, c);
        end
    endtask

    task automatic do_reset();
        din_valid = 1'b0;
        din       = 1'b0;
        clear     = 1'b0;
        RN        = 1'b0;
        @(posedge CK);
        #1;
        RN          = 1'b1;
        g           = 7'h7F;
        pulse_cnt   = 0;
        locked_seen = 0;
    endtask

    initial begin
        #2;
        check("rst_locked", 32'(locked), 0);
        check("rst_pulse", 32'(err_pulse), 0);
        check("rst_count", 32'(err_count), 0);

        // Clean stream: lock on valid bit 23, then 1000 error-free bits.
        do_reset();
        prbs_bits(22, 1'b0, 1'b0);
        check("lock_not_yet_22", 32'(locked), 0);
        prbs_bits(1, 1'b0, 1'b0);
        check("lock_at_23", 32'(locked), 1);
        pulse_cnt = 0;
        prbs_bits(1000, 1'b0, 1'b0);
        check("clean_pulses", 32'(pulse_cnt), 0);
        check("clean_count", 32'(err_count), 0);
        check("clean_locked", 32'(locked), 1);

        // Three isolated errors: single-cycle pulses, lock retained.
        do_reset();
        prbs_bits(23, 1'b0, 1'b0);
        pulse_cnt = 0;
        for (int e = 0; e < 3; e++) begin
            prbs_bits(9, 1'b0, 1'b0);
            prbs_bits(1, 1'b1, 1'b0);
            check("iso_pulse_hi", 32'(err_pulse), 1);
            prbs_bits(1, 1'b0, 1'b0);
            check("iso_pulse_lo", 32'(err_pulse), 0);
        end
        check("iso_count", 32'(err_count), 3);
        check("iso_pulses", 32'(pulse_cnt), 3);
        check("iso_locked", 32'(locked), 1);

        // Four errors in one window: unlock with the 4th pulse, relock 23 bits later.
        do_reset();
        prbs_bits(23, 1'b0, 1'b0);
        for (int e = 0; e < 3; e++) begin
            prbs_bits(5, 1'b0, 1'b0);
            prbs_bits(1, 1'b1, 1'b0);
        end
        check("unlk_still_locked", 32'(locked), 1);
        prbs_bits(5, 1'b0, 1'b0);
        prbs_bits(1, 1'b1, 1'b0);
        check("unlk_locked", 32'(locked), 0);
        check("unlk_pulse", 32'(err_pulse), 1);
        check("unlk_count", 32'(err_count), 4);
        prbs_bits(22, 1'b0, 1'b0);
        check("relock_22", 32'(locked), 0);
        prbs_bits(1, 1'b0, 1'b0);
        check("relock_23", 32'(locked), 1);
        check("relock_count", 32'(err_count), 4);

        // Window wrap: errors on window bits 124..127 and 130 never reach 4 in one window.
        do_reset();
        prbs_bits(23, 1'b0, 1'b0);
        prbs_bits(124, 1'b0, 1'b0);
        prbs_bits(3, 1'b1, 1'b0);
        check("wrap_count3", 32'(err_count), 3);
        prbs_bits(1, 1'b1, 1'b0);
        check("wrap_bit_locked", 32'(locked), 1);
        prbs_bits(2, 1'b0, 1'b0);
        prbs_bits(1, 1'b1, 1'b0);
        check("wrap_after_locked", 32'(locked), 1);
        check("wrap_count5", 32'(err_count), 5);

        // Asynchronous reset while locked with a pending pulse.
        #2;
        RN = 1'b0;
        #1;
        check("arst_locked", 32'(locked), 0);
        check("arst_pulse", 32'(err_pulse), 0);
        check("arst_count", 32'(err_count), 0);
        @(posedge CK);
        #1;
        RN = 1'b1;
        g  = 7'h7F;

        // Constant zero input never locks.
        do_reset();
        for (int i = 0; i < 500; i++) step(1'b1, 1'b0, 1'b0);
        check("zero_never_locks", 32'(locked_seen), 0);
        check("zero_count", 32'(err_count), 0);

        // Inverted stream while locked: 4-bit counter saturates, default unlocks at 4.
        do_reset();
        prbs_bits(23, 1'b0, 1'b0);
        prbs_bits(15, 1'b1, 1'b0);
        check("sat_reach15", 32'(err_count4), 15);
        prbs_bits(5, 1'b1, 1'b0);
        check("sat_hold15", 32'(err_count4), 15);
        check("sat_locked4", 32'(locked4), 1);
        check("inv_count_default", 32'(err_count), 4);
        check("inv_unlocked_default", 32'(locked), 0);

        // Clear coinciding with an error, then a plain clear.
        do_reset();
        prbs_bits(23, 1'b0, 1'b0);
        prbs_bits(3, 1'b0, 1'b0);
        prbs_bits(1, 1'b1, 1'b0);
        prbs_bits(3, 1'b0, 1'b0);
        prbs_bits(1, 1'b1, 1'b0);
        check("clr_pre_count", 32'(err_count), 2);
        prbs_bits(1, 1'b1, 1'b1);
        check("clr_err_count", 32'(err_count), 1);
        check("clr_err_pulse", 32'(err_pulse), 1);
        prbs_bits(1, 1'b0, 1'b1);
        check("clr_plain_count", 32'(err_count), 0);
        check("clr_locked", 32'(locked), 1);

        // Gapped input: lock latency counted in valid bits only.
        do_reset();
        for (int i = 0; i < 22; i++) begin
            prbs_bits(1, 1'b0, 1'b0);
            step(1'b0, 1'b1, 1'b0);
        end
        check("gap_lock_22", 32'(locked), 0);
        prbs_bits(1, 1'b0, 1'b0);
        check("gap_lock_23", 32'(locked), 1);
        step(1'b0, ~(g[6] ^ g[5]), 1'b0);
        check("gap_invalid_pulse", 32'(err_pulse), 0);
        check("gap_invalid_count", 32'(err_count), 0);
        prbs_bits(1, 1'b0, 1'b0);
        check("gap_clean_pulse", 32'(err_pulse), 0);
        check("gap_still_locked", 32'(locked), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prbs7_checker.md
PRBS7_CHECKER -- requirements
Module: prbs7_checker

Interface
REQ-001 Parameter LOCK_CNT, default 16: consecutive matching bits required in SEARCH to declare lock (range 1..255).
REQ-002 Parameter UNLOCK_ERR, default 4: errors within one 128-bit window that force loss of lock (range 1..127).
REQ-003 Parameter CNT_W, default 16: width of the error counter.
REQ-004 CK  input  1  single clock; all state updates on rising edge.
REQ-005 RN  input  1  asynchronous active-low reset.
REQ-006 din_valid  input  1  qualifies din; no state advances when low.
REQ-007 din  input  1  serial PRBS7 data bit, sampled when din_valid=1.
REQ-008 clear  input  1  synchronous error-counter clear, level-sensitive.
REQ-009 locked  output  1  registered; high while the FSM is in LOCKED.
REQ-010 err_pulse  output  1  registered one-cycle flag per bit error detected in LOCKED.
REQ-011 err_count  output  CNT_W  registered, saturating count of bit errors detected in LOCKED.

Function
REQ-012 Polynomial x^7+x^6+1; 7-bit state sr[6:0]; predicted bit p = sr[6] XOR sr[5].
REQ-013 FSM has two states, SEARCH and LOCKED; reset state is SEARCH.
REQ-014 SEARCH, per valid bit: sr <= {sr[5:0], din} (self-seeding from the input).
REQ-015 SEARCH: a fill counter ignores comparison for the first 7 valid bits after entry.
REQ-016 SEARCH after fill: din==p and sr!=0 increments match_cnt; any other case clears match_cnt to 0.
REQ-017 SEARCH: the all-zero state never counts as a match, so a constant-0 stream never locks.
REQ-018 SEARCH: when match_cnt reaches LOCK_CNT, the FSM enters LOCKED and locked=1 on the next edge.
REQ-019 Ideal PRBS input: locked rises on the edge that samples valid bit number 7+LOCK_CNT (23 by default).
REQ-020 SEARCH: mismatches produce no err_pulse and do not change err_count.
REQ-021 LOCKED, per valid bit: sr <= {sr[5:0], p} (free-running reference, independent of din).
REQ-022 LOCKED: din!=p sets err_pulse=1 for exactly one cycle, starting the edge after sampling; otherwise err_pulse=0.
REQ-023 err_count increments by 1 per LOCKED error and holds at 2^CNT_W-1 (no wrap).
REQ-024 LOCKED: a 7-bit window counter counts valid bits and wraps 127->0.
REQ-025 LOCKED: err_win counts errors within the window and resets to 0 at wrap.
REQ-026 Error on the wrap bit: err_win becomes 1.
REQ-027 When err_win reaches UNLOCK_ERR: FSM returns to SEARCH and locked=0 on the same edge the final err_pulse rises.
REQ-028 The triggering error is counted in err_count and flagged on err_pulse.
REQ-029 On entry to SEARCH, fill counter, match_cnt, window counter and err_win are cleared; sr is retained.
REQ-030 clear=1 sets err_count to 0 on the next edge.
REQ-031 clear and an error in the same cycle: err_count becomes 1 and err_pulse still asserts.
REQ-032 clear has no effect on FSM state, sr, or err_pulse.
REQ-033 din_valid=0: all state and counters hold; err_pulse=0.

Reset
REQ-034 RN=0 asynchronously forces state=SEARCH, sr=0, all internal counters=0, locked=0, err_pulse=0, err_count=0.
REQ-035 Reset mid-operation (including while LOCKED) behaves identically to power-up; no history survives.
REQ-036 Deassertion of RN takes effect at the first rising CK edge after RN=1.

Verification
REQ-037 Clean PRBS7 seeded 7'h7F, din_valid=1 continuously -> locked rises after 23 bits; err_pulse=0 and err_count=0 for 1000 further bits.
REQ-038 After lock, invert 3 isolated bits within one window -> three single-cycle err_pulse; err_count=3; locked stays 1.
REQ-039 After lock, invert 4 bits within one 128-bit window -> err_count=4; locked falls with the 4th err_pulse; relock 23 bits later.
REQ-040 Constant-0 input for 500 bits -> locked never rises; err_count=0.
REQ-041 CNT_W=4, continuous inverted stream while locked -> err_count saturates at 15.
REQ-042 Clear: clear asserted on an error cycle -> err_count=1. Gaps: din_valid toggling every cycle -> lock latency counted in valid bits only (23).
REQ-043 Reset pulse while LOCKED with err_count=5 -> all outputs 0 immediately, without waiting for a clock edge.
